// File: rtl/core_pkg.sv
// Shared types and constants for the RV32I pipeline front end.
package core_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;

  typedef enum logic [1:0] {
    STEP_ADVANCE  = 2'd0,
    STEP_STALL    = 2'd1,
    STEP_REDIRECT = 2'd2
  } step_e;

  // Redirect beats stall beats advance; exactly one action per edge.
  function automatic step_e step_sel(input logic redirect, input logic stall);
    if (redirect)   return STEP_REDIRECT;
    else if (stall) return STEP_STALL;
    else            return STEP_ADVANCE;
  endfunction

endpackage

// File: rtl/pc_gen.sv
// Fetch PC register: sequential advance with wrap, masked redirect targets,
// and a registered one-cycle flag for misaligned redirect targets.
module pc_gen
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] pc_o,
  output logic        misalign_o
);

  localparam logic [31:0] PC_SPAN = 32'(IMEM_WORDS * 4);
  localparam logic [31:0] PC_LAST = PC_SPAN - 32'd4;

  logic [31:0] pc_q, pc_d;
  logic        misalign_q, misalign_d;
  logic [31:0] target_word;

  assign target_word = {redirect_pc_i[31:2], 2'b00};

  always_comb begin
    pc_d       = pc_q;
    misalign_d = 1'b0;
    case (step_sel(redirect_i, stall_i))
      STEP_REDIRECT: begin
        pc_d       = target_word % PC_SPAN;
        misalign_d = |redirect_pc_i[1:0];
      end
      STEP_STALL: pc_d = pc_q;
      default:    pc_d = (pc_q >= PC_LAST) ? 32'd0 : pc_q + 32'd4;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  assign pc_o       = pc_q;
  assign misalign_o = misalign_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: drives the instruction-memory address, captures the returned word
// into IF/ID, applies stalls and redirects, and counts fetches and bubbles.
module fetch_stage
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 1024,
  parameter int          CNT_W      = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             redirect_i,
  input  logic [31:0]      redirect_pc_i,
  input  logic [31:0]      instr_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      if_id_pc_o,
  output logic [31:0]      if_id_instr_o,
  output logic             if_id_valid_o,
  output logic             misalign_o,
  output logic [CNT_W-1:0] fetch_cnt_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  localparam if_id_t IF_ID_BUBBLE = '{pc: 32'd0, instr: NOP_INSTR, valid: 1'b0};

  if_id_t            if_id_q, if_id_d;
  logic [CNT_W-1:0]  fetch_cnt_q, fetch_cnt_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
  logic [31:0]       pc;

  pc_gen #(
    .RESET_PC   (RESET_PC),
    .IMEM_WORDS (IMEM_WORDS)
  ) u_pc_gen (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .pc_o          (pc),
    .misalign_o    (misalign_o)
  );

  // Counters stick at all-ones rather than wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    if_id_d      = if_id_q;
    fetch_cnt_d  = fetch_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    case (step_sel(redirect_i, stall_i))
      STEP_REDIRECT: begin
        if_id_d      = IF_ID_BUBBLE;
        bubble_cnt_d = sat_inc(bubble_cnt_q);
      end
      STEP_STALL: begin
        if_id_d = if_id_q;
      end
      default: begin
        if_id_d     = '{pc: pc, instr: instr_i, valid: 1'b1};
        fetch_cnt_d = sat_inc(fetch_cnt_q);
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      if_id_q      <= IF_ID_BUBBLE;
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if_id_q      <= if_id_d;
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign pc_o          = pc;
  assign if_id_pc_o    = if_id_q.pc;
  assign if_id_instr_o = if_id_q.instr;
  assign if_id_valid_o = if_id_q.valid;
  assign fetch_cnt_o   = fetch_cnt_q;
  assign bubble_cnt_o  = bubble_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, advance, stall, redirect, misalign,
// async reset, and PC wrap on a small-memory instance.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] ADD_W3 = 32'h0020_81B3;
  localparam logic [31:0] AND_W12 = 32'h0020_F633;

  logic        clk = 1'b0;
  logic        rst, stall, redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr, pc, if_id_pc, if_id_instr;
  logic        if_id_valid, misalign;
  logic [31:0] fetch_cnt, bubble_cnt;

  logic        rst_w;
  logic [31:0] instr_w, pc_w, if_id_pc_w, if_id_instr_w;
  logic        if_id_valid_w, misalign_w;
  logic [31:0] fetch_cnt_w, bubble_cnt_w;

  logic [31:0] imem [0:1023];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign instr   = imem[pc[11:2]];
  assign instr_w = imem[pc_w[11:2]];

  fetch_stage dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .instr_i       (instr),
    .pc_o          (pc),
    .if_id_pc_o    (if_id_pc),
    .if_id_instr_o (if_id_instr),
    .if_id_valid_o (if_id_valid),
    .misalign_o    (misalign),
    .fetch_cnt_o   (fetch_cnt),
    .bubble_cnt_o  (bubble_cnt)
  );

  fetch_stage #(.IMEM_WORDS(4)) dut_wrap (
    .clk_i         (clk),
    .rst_i         (rst_w),
    .stall_i       (1'b0),
    .redirect_i    (1'b0),
    .redirect_pc_i (32'd0),
    .instr_i       (instr_w),
    .pc_o          (pc_w),
    .if_id_pc_o    (if_id_pc_w),
    .if_id_instr_o (if_id_instr_w),
    .if_id_valid_o (if_id_valid_w),
    .misalign_o    (misalign_w),
    .fetch_cnt_o   (fetch_cnt_w),
    .bubble_cnt_o  (bubble_cnt_w)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) imem[i] = NOP;
    imem[3]  = ADD_W3;
    imem[12] = AND_W12;
    rst = 1'b1; rst_w = 1'b1;
    stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;

    // Reset values
    step(); step();
    check("rst_pc", pc, 32'h0);
    check("rst_valid", {31'd0, if_id_valid}, 32'd0);
    check("rst_instr", if_id_instr, NOP);
    check("rst_ifpc", if_id_pc, 32'h0);
    check("rst_fcnt", fetch_cnt, 32'd0);
    check("rst_bcnt", bubble_cnt, 32'd0);
    check("rst_misalign", {31'd0, misalign}, 32'd0);
    rst = 1'b0;

    // Four free advances
    repeat (4) step();
    check("adv_pc", pc, 32'h10);
    check("adv_ifpc", if_id_pc, 32'hC);
    check("adv_instr", if_id_instr, ADD_W3);
    check("adv_valid", {31'd0, if_id_valid}, 32'd1);
    check("adv_fcnt", fetch_cnt, 32'd4);

    // Stall at pc 0x14
    step();
    check("pre_stall_pc", pc, 32'h14);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", pc, 32'h14);
      check("stall_ifpc", if_id_pc, 32'h10);
      check("stall_fcnt", fetch_cnt, 32'd5);
    end
    stall = 1'b0;
    step();
    check("unstall_ifpc", if_id_pc, 32'h14);
    check("unstall_pc", pc, 32'h18);
    check("unstall_fcnt", fetch_cnt, 32'd6);

    // Redirect to 0x30
    redirect = 1'b1; redirect_pc = 32'h30;
    step();
    redirect = 1'b0;
    check("redir_pc", pc, 32'h30);
    check("redir_valid", {31'd0, if_id_valid}, 32'd0);
    check("redir_instr", if_id_instr, NOP);
    check("redir_ifpc", if_id_pc, 32'h0);
    check("redir_bcnt", bubble_cnt, 32'd1);
    check("redir_fcnt", fetch_cnt, 32'd6);
    check("redir_misalign", {31'd0, misalign}, 32'd0);
    step();
    check("post_redir_instr", if_id_instr, AND_W12);
    check("post_redir_ifpc", if_id_pc, 32'h30);
    check("post_redir_pc", pc, 32'h34);
    check("post_redir_fcnt", fetch_cnt, 32'd7);

    // Redirect + stall together, misaligned target
    redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h32;
    step();
    redirect = 1'b0;
    check("rs_pc", pc, 32'h30);
    check("rs_valid", {31'd0, if_id_valid}, 32'd0);
    check("rs_instr", if_id_instr, NOP);
    check("rs_misalign", {31'd0, misalign}, 32'd1);
    check("rs_bcnt", bubble_cnt, 32'd2);
    step();
    check("rs_misalign_off", {31'd0, misalign}, 32'd0);
    check("rs_hold_pc", pc, 32'h30);
    check("rs_hold_bcnt", bubble_cnt, 32'd2);

    // Async reset mid-cycle during a stall
    step();
    #2 rst = 1'b1;
    #1;
    check("arst_pc", pc, 32'h0);
    check("arst_valid", {31'd0, if_id_valid}, 32'd0);
    check("arst_instr", if_id_instr, NOP);
    check("arst_fcnt", fetch_cnt, 32'd0);
    check("arst_bcnt", bubble_cnt, 32'd0);
    step();
    rst = 1'b0; stall = 1'b0;

    // Wrap with IMEM_WORDS = 4
    rst_w = 1'b0;
    check("wrap_pc0", pc_w, 32'h0);
    step(); check("wrap_pc1", pc_w, 32'h4);
    step(); check("wrap_pc2", pc_w, 32'h8);
    step(); check("wrap_pc3", pc_w, 32'hC);
    step(); check("wrap_pc4", pc_w, 32'h0);
    check("wrap_ifpc4", if_id_pc_w, 32'hC);
    step(); check("wrap_pc5", pc_w, 32'h4);
    check("wrap_fcnt", fetch_cnt_w, 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
